// File: rtl/result_collector.sv
// result_collector
//   Receives the systolic array's bit-serial result stream. It rebuilds each
//   result into a 2*D_W-bit word and tags the word with its (row, col)
//   position. Finished words are queued in a small FIFO, and the FIFO head is
//   presented on a valid/ready interface.
//
// Ports
//   clk        system clock
//   rst        asynchronous active-high reset
//   clear      synchronous flush of counters, FIFO and overflow flag
//   ser_in     serial result bit, LSB first
//   ser_valid  ser_in carries a valid bit this cycle
//   out_data   assembled result word at the FIFO head
//   out_row    row index of out_data
//   out_col    column index of out_data
//   out_last   out_data is element (N-1, N-1) of its frame
//   out_valid  FIFO head is valid
//   out_ready  consumer accepts the head this cycle
//   frame_done one-cycle pulse after the last word of a frame is assembled
//   overflow   sticky: a completed word was dropped because the FIFO was full
module result_collector #(
  parameter int D_W   = 8,
  parameter int N     = 2,
  parameter int DEPTH = 4,
  localparam int IW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              ser_in,
  input  logic              ser_valid,
  output logic [2*D_W-1:0]  out_data,
  output logic [IW-1:0]     out_row,
  output logic [IW-1:0]     out_col,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              frame_done,
  output logic              overflow
);

  localparam int WW = 2 * D_W;
  localparam int BW = $clog2(WW);
  localparam int PW = $clog2(DEPTH);
  localparam logic [BW-1:0] BIT_LAST = BW'(WW - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

  typedef struct packed {
    logic [WW-1:0] data;
    logic [IW-1:0] row;
    logic [IW-1:0] col;
    logic          last;
  } entry_t;

  logic [BW-1:0] bit_cnt_reg, bit_cnt_next;
  logic [IW-1:0] row_reg, row_next;
  logic [IW-1:0] col_reg, col_next;
  logic [WW-1:0] shift_reg, shift_next;
  // One extra pointer bit tells full apart from empty when the indices match.
  logic [PW:0]   wr_ptr_reg, wr_ptr_next;
  logic [PW:0]   rd_ptr_reg, rd_ptr_next;
  logic          frame_done_reg, frame_done_next;
  logic          overflow_reg, overflow_next;
  entry_t        mem [DEPTH];
  entry_t        wr_entry;

  logic fifo_empty, fifo_full, pop, push, word_done, elem_last;

  always_comb begin
    fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    fifo_full  = (wr_ptr_reg[PW] != rd_ptr_reg[PW]) &&
                 (wr_ptr_reg[PW-1:0] == rd_ptr_reg[PW-1:0]);
    pop        = !fifo_empty && out_ready;
    elem_last  = (row_reg == IDX_LAST) && (col_reg == IDX_LAST);
    word_done  = ser_valid && (bit_cnt_reg == BIT_LAST);

    shift_next      = shift_reg;
    bit_cnt_next    = bit_cnt_reg;
    row_next        = row_reg;
    col_next        = col_reg;
    frame_done_next = 1'b0;
    overflow_next   = overflow_reg;

    if (ser_valid) begin
      // LSB arrives first: new bits enter at the top and move down.
      shift_next   = {ser_in, shift_reg[WW-1:1]};
      bit_cnt_next = word_done ? '0 : bit_cnt_reg + BW'(1);
    end

    // A slot being popped this cycle can take the new word in the same cycle.
    push = word_done && (!fifo_full || pop);

    wr_entry.data = shift_next;
    wr_entry.row  = row_reg;
    wr_entry.col  = col_reg;
    wr_entry.last = elem_last;

    // Indices advance even when the word is dropped so the next frame stays aligned.
    if (word_done) begin
      frame_done_next = elem_last;
      if (!push)
        overflow_next = 1'b1;
      if (col_reg == IDX_LAST) begin
        col_next = '0;
        row_next = (row_reg == IDX_LAST) ? '0 : row_reg + IW'(1);
      end else begin
        col_next = col_reg + IW'(1);
      end
    end

    wr_ptr_next = wr_ptr_reg + {{PW{1'b0}}, push};
    rd_ptr_next = rd_ptr_reg + {{PW{1'b0}}, pop};

    if (clear) begin
      shift_next      = '0;
      bit_cnt_next    = '0;
      row_next        = '0;
      col_next        = '0;
      wr_ptr_next     = '0;
      rd_ptr_next     = '0;
      frame_done_next = 1'b0;
      overflow_next   = 1'b0;
      push            = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg      <= '0;
      bit_cnt_reg    <= '0;
      row_reg        <= '0;
      col_reg        <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      frame_done_reg <= 1'b0;
      overflow_reg   <= 1'b0;
    end else begin
      shift_reg      <= shift_next;
      bit_cnt_reg    <= bit_cnt_next;
      row_reg        <= row_next;
      col_reg        <= col_next;
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      frame_done_reg <= frame_done_next;
      overflow_reg   <= overflow_next;
    end
  end

  // Storage is cleared on reset so the head reads as all zeros while empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr_reg[PW-1:0]] <= wr_entry;
    end
  end

  assign out_data   = mem[rd_ptr_reg[PW-1:0]].data;
  assign out_row    = mem[rd_ptr_reg[PW-1:0]].row;
  assign out_col    = mem[rd_ptr_reg[PW-1:0]].col;
  assign out_last   = mem[rd_ptr_reg[PW-1:0]].last;
  assign out_valid  = !fifo_empty;
  assign frame_done = frame_done_reg;
  assign overflow   = overflow_reg;

endmodule

// File: tb/tb_result_collector.sv
module tb_result_collector;

  localparam int D_W   = 8;
  localparam int N     = 2;
  localparam int DEPTH = 4;
  localparam int WW    = 2 * D_W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear = 1'b0;
  logic          ser_in = 1'b0;
  logic          ser_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic [WW-1:0] out_data;
  logic [0:0]    out_row, out_col;
  logic          out_last, out_valid, frame_done, overflow;

  result_collector #(.D_W(D_W), .N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .clear(clear), .ser_in(ser_in), .ser_valid(ser_valid),
    .out_data(out_data), .out_row(out_row), .out_col(out_col), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready), .frame_done(frame_done),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [WW-1:0] d;
    int            row;
    int            col;
    bit            last;
  } ent_t;

  ent_t          m_q[$];
  int            m_bits = 0;
  int            m_elem = 0;
  logic [WW-1:0] m_word = '0;
  bit            m_ovf = 1'b0;
  bit            m_fd = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete(); m_bits = 0; m_elem = 0; m_word = '0; m_ovf = 1'b0; m_fd = 1'b0;
    end else if (clear) begin
      m_q.delete(); m_bits = 0; m_elem = 0; m_word = '0; m_ovf = 1'b0; m_fd = 1'b0;
    end else begin
      bit   do_pop;
      ent_t e;
      m_fd   = 1'b0;
      do_pop = (m_q.size() > 0) && out_ready;
      if (do_pop) void'(m_q.pop_front());
      if (ser_valid) begin
        m_word[m_bits] = ser_in;
        m_bits++;
        if (m_bits == WW) begin
          e.d    = m_word;
          e.row  = m_elem / N;
          e.col  = m_elem % N;
          e.last = (m_elem == N * N - 1);
          if (m_q.size() < DEPTH) m_q.push_back(e);
          else m_ovf = 1'b1;
          m_fd   = e.last;
          m_elem = (m_elem + 1) % (N * N);
          m_bits = 0;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("out_valid", {31'b0, out_valid}, {31'b0, m_q.size() != 0});
    chk("overflow", {31'b0, overflow}, {31'b0, m_ovf});
    chk("frame_done", {31'b0, frame_done}, {31'b0, m_fd});
    if (m_q.size() != 0) begin
      chk("out_data", {16'b0, out_data}, {16'b0, m_q[0].d});
      chk("out_row", {31'b0, out_row}, m_q[0].row);
      chk("out_col", {31'b0, out_col}, m_q[0].col);
      chk("out_last", {31'b0, out_last}, {31'b0, m_q[0].last});
    end
  end

  // Log of accepted words for the hand-computed expectations.
  logic [WW-1:0] acc_d[$];
  int            acc_rc[$];
  bit            acc_last[$];

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      acc_d.push_back(out_data);
      acc_rc.push_back(int'(out_row) * N + int'(out_col));
      acc_last.push_back(out_last);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_bits(input logic [WW-1:0] v, input int lo, input int hi, input bit gap);
    for (int i = lo; i <= hi; i++) begin
      @(posedge clk); #2;
      ser_valid = 1'b1;
      ser_in    = v[i];
      if (gap && i != hi) begin
        @(posedge clk); #2;
        ser_valid = 1'b0;
        ser_in    = ~ser_in;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #2;
      ser_valid = 1'b0;
      ser_in    = 1'b0;
    end
  endtask

  task automatic do_clear();
    @(posedge clk); #2;
    clear = 1'b1; ser_valid = 1'b0;
    @(posedge clk); #2;
    clear = 1'b0;
  endtask

  task automatic clear_log();
    acc_d.delete(); acc_rc.delete(); acc_last.delete();
  endtask

  task automatic chk_log(input string name, input int idx, input logic [WW-1:0] d, input int rc);
    if (idx < acc_d.size()) begin
      chk({name, "_data"}, {16'b0, acc_d[idx]}, {16'b0, d});
      chk({name, "_idx"}, acc_rc[idx], rc);
    end else begin
      chk({name, "_present"}, acc_d.size(), idx + 1);
    end
  endtask

  logic [WW-1:0] words1 [4] = '{16'h0001, 16'h00FF, 16'h1234, 16'hFFFF};
  logic [WW-1:0] words3 [8] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444,
                                16'h5555, 16'h6666, 16'h7777, 16'h8888};
  int fd_count;

  always @(negedge clk) if (frame_done) fd_count++;

  initial begin
    fd_count = 0;
    // Reset state.
    @(posedge clk); #2;
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_out_data", {16'b0, out_data}, 0);
    chk("rst_out_row", {31'b0, out_row}, 0);
    chk("rst_out_col", {31'b0, out_col}, 0);
    chk("rst_out_last", {31'b0, out_last}, 0);
    chk("rst_frame_done", {31'b0, frame_done}, 0);
    chk("rst_overflow", {31'b0, overflow}, 0);
    rst = 1'b0;
    idle(2);

    // 1: contiguous frame, consumer always ready.
    clear_log();
    fd_count = 0;
    for (int w = 0; w < 4; w++) send_bits(words1[w], 0, WW - 1, 1'b0);
    idle(1);
    @(negedge clk);
    chk("t1_frame_done_after_bit63", {31'b0, frame_done}, 1);
    idle(4);
    chk("t1_count", acc_d.size(), 4);
    chk_log("t1_w0", 0, 16'h0001, 0);
    chk_log("t1_w1", 1, 16'h00FF, 1);
    chk_log("t1_w2", 2, 16'h1234, 2);
    chk_log("t1_w3", 3, 16'hFFFF, 3);
    if (acc_last.size() == 4) begin
      chk("t1_last_w2", {31'b0, acc_last[2]}, 0);
      chk("t1_last_w3", {31'b0, acc_last[3]}, 1);
    end
    chk("t1_frame_done_pulses", fd_count, 1);

    // 2: same frame, ser_valid toggling every cycle.
    clear_log();
    for (int w = 0; w < 4; w++) send_bits(words1[w], 0, WW - 1, 1'b1);
    idle(5);
    chk("t2_count", acc_d.size(), 4);
    chk_log("t2_w0", 0, 16'h0001, 0);
    chk_log("t2_w2", 2, 16'h1234, 2);
    chk_log("t2_w3", 3, 16'hFFFF, 3);

    // 3: consumer stalled across two frames -> overflow, then drain.
    clear_log();
    out_ready = 1'b0;
    for (int w = 0; w < 8; w++) send_bits(words3[w], 0, WW - 1, 1'b0);
    idle(1);
    @(negedge clk);
    chk("t3_overflow", {31'b0, overflow}, 1);
    chk("t3_valid_held", {31'b0, out_valid}, 1);
    chk("t3_head_held", {16'b0, out_data}, 16'h1111);
    out_ready = 1'b1;
    idle(8);
    chk("t3_drain_count", acc_d.size(), 4);
    chk_log("t3_w0", 0, 16'h1111, 0);
    chk_log("t3_w3", 3, 16'h4444, 3);
    send_bits(16'h9999, 0, WW - 1, 1'b0);
    idle(3);
    chk_log("t3_next_frame", 4, 16'h9999, 0);
    chk("t3_overflow_sticky", {31'b0, overflow}, 1);

    // 4: FIFO full, word completes on the same cycle as a pop.
    do_clear();
    clear_log();
    out_ready = 1'b0;
    for (int w = 0; w < 4; w++) send_bits(words3[w], 0, WW - 1, 1'b0);
    send_bits(16'hA5A5, 0, WW - 2, 1'b0);
    @(posedge clk); #2;
    ser_valid = 1'b1; ser_in = 1'b1; out_ready = 1'b1;
    @(posedge clk); #2;
    ser_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("t4_no_overflow", {31'b0, overflow}, 0);
    chk("t4_head_after_pop", {16'b0, out_data}, 16'h2222);
    out_ready = 1'b1;
    idle(6);
    chk("t4_drain_count", acc_d.size(), 5);
    chk_log("t4_w4", 4, 16'hA5A5, 0);

    // 5: clear in the middle of a word discards the partial bits.
    do_clear();
    clear_log();
    send_bits(16'h00A5, 0, 4, 1'b0);
    @(posedge clk); #2;
    clear = 1'b1; ser_valid = 1'b1; ser_in = 1'b1;
    @(posedge clk); #2;
    clear = 1'b0; ser_valid = 1'b0;
    send_bits(16'hBEEF, 0, WW - 1, 1'b0);
    idle(4);
    chk("t5_count", acc_d.size(), 1);
    chk_log("t5_w0", 0, 16'hBEEF, 0);

    // 6: asynchronous reset mid-frame, mid-word.
    out_ready = 1'b0;
    send_bits(16'h1234, 0, WW - 1, 1'b0);
    send_bits(16'h5555, 0, 6, 1'b0);
    @(posedge clk); #2;
    ser_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("t6_async_out_valid", {31'b0, out_valid}, 0);
    chk("t6_async_out_data", {16'b0, out_data}, 0);
    chk("t6_async_out_col", {31'b0, out_col}, 0);
    @(posedge clk); #2;
    rst = 1'b0;
    out_ready = 1'b1;
    clear_log();
    send_bits(16'h8001, 0, WW - 1, 1'b0);
    idle(3);
    chk("t6_count", acc_d.size(), 1);
    chk_log("t6_w0", 0, 16'h8001, 0);

    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
